// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, state encoding and saturation value for the 16/8 divider
package div_pkg;

  localparam int NW    = 16;
  localparam int DW    = 8;
  localparam int CNT_W = $clog2(DW);

  localparam logic [DW-1:0] Q_SAT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_16x8_seq_if.sv
// rtl/div_16x8_seq_if.sv - operand/result handshake bundle for the 16/8 divider
interface div_16x8_seq_if;
  import div_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] R;
  logic [DW-1:0] B;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quot;
  logic [DW-1:0] rem;
  logic          dz;
  logic          ovf;

  modport master (
    output in_valid, R, B, out_ready,
    input  in_ready, out_valid, quot, rem, dz, ovf
  );

  modport slave (
    input  in_valid, R, B, out_ready,
    output in_ready, out_valid, quot, rem, dz, ovf
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
  import div_pkg::*;
(
  input  logic [DW-1:0] r,
  input  logic          bit_in,
  input  logic [DW-1:0] B,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);

  logic [DW:0] w_t;

  assign w_t   = {r, bit_in};
  assign q_bit = (w_t >= {1'b0, B});
  // r < B on entry, so the true difference always fits in DW bits
  assign r_next = q_bit ? (w_t[DW-1:0] - B) : w_t[DW-1:0];

endmodule

// File: rtl/div_16x8_seq.sv
// rtl/div_16x8_seq.sv - iterative radix-2 restoring divider, one quotient bit per clock
module div_16x8_seq
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  div_16x8_seq_if.slave   bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DW-1:0]     r_acc;
  logic [DW-1:0]     r_div;
  logic [DW-1:0]     r_shift;
  logic [DW-1:0]     r_quot;
  logic [DW-1:0]     r_rem;
  logic              r_dz;
  logic              r_ovf;

  logic              w_accept;
  logic              w_dz;
  logic              w_ovf;
  logic              w_last;
  logic              w_q_bit;
  logic [DW-1:0]     w_acc_nxt;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_dz     = (bus.B == '0);
  assign w_ovf    = !w_dz && (bus.R[NW-1:DW] >= bus.B);
  assign w_last   = (r_cnt == CNT_W'(DW-1));

  div_step u_step (
    .r      (r_acc),
    .bit_in (r_shift[DW-1]),
    .B      (r_div),
    .r_next (w_acc_nxt),
    .q_bit  (w_q_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (w_dz || w_ovf) ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Quotient bits enter the shift register from the bottom as dividend bits leave the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_div   <= '0;
      r_shift <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div   <= bus.B;
            r_shift <= bus.R[DW-1:0];
            r_acc   <= bus.R[NW-1:DW];
            r_cnt   <= '0;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf;
            if (w_dz || w_ovf) begin
              r_quot <= Q_SAT;
              r_rem  <= '0;
            end
          end
        end
        CALC: begin
          r_acc   <= w_acc_nxt;
          r_shift <= {r_shift[DW-2:0], w_q_bit};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quot <= {r_shift[DW-2:0], w_q_bit};
            r_rem  <= w_acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.quot      = r_quot;
  assign bus.rem       = r_rem;
  assign bus.dz        = r_dz;
  assign bus.ovf       = r_ovf;

endmodule
